// File: rtl/risc8_pin_input_pkg.sv
// Shared helpers for the pin input conditioning block.
package risc8_pin_input_pkg;

  // Width of a debounce counter that must count 0 .. cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/risc8_pin_input_bit.sv
// One pin: two-flop synchronizer, stability counter, debounced level and
// registered rise/fall pulses.
module risc8_pin_input_bit
  import risc8_pin_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronize the pad, then accept a new level only after CNT_MAX+1
  // consecutive disagreeing samples; pulses last one cycle after the change.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // which is what makes s1 -> s2 a real two-stage synchronizer.
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= pin_raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/risc8_pin_input.sv
// Debounced GPIO input block: per-pin conditioning plus latched rising-edge
// pending bits and a maskable interrupt request.
module risc8_pin_input
  import risc8_pin_input_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pin_b,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] pending_clr,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    risc8_pin_input_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .pin_raw(pins_in[i]),
      .level  (pin_b[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Latch rising edges; a clear strobe loses to a simultaneous new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pending_clr) | rise;
    end
  end

  assign irq = |(pending & irq_mask);

endmodule

// File: tb/tb_risc8_pin_input.sv
// Directed bench for risc8_pin_input (WIDTH=8, DEBOUNCE_CYCLES=4). Stimulus
// queues the expected rise/fall events; a negedge monitor pops and compares
// them whenever the DUT emits a pulse.
module tb_risc8_pin_input;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] pin_b;
  } evt_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pins_in;
  logic [W-1:0] pin_b;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] irq_mask;
  logic [W-1:0] pending_clr;
  logic [W-1:0] pending;
  logic         irq;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  evt_t exp_q[$];

  risc8_pin_input #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pins_in    (pins_in),
    .pin_b      (pin_b),
    .rise       (rise),
    .fall       (fall),
    .irq_mask   (irq_mask),
    .pending_clr(pending_clr),
    .pending    (pending),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%02h expected 0x%02h", name, cyc, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a pulse visible after the dt-th edge from now.
  task automatic expect_evt(input int dt, input logic [7:0] r, input logic [7:0] f,
                            input logic [7:0] pb);
    evt_t e;
    e.cyc   = cyc + dt;
    e.rise  = r;
    e.fall  = f;
    e.pin_b = pb;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if ((rise | fall) != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse @cyc %0d: rise=0x%02h fall=0x%02h", cyc, rise, fall);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.rise !== rise || e.fall !== fall || e.pin_b !== pin_b) begin
          errors++;
          $display("FAIL pulse_event: got cyc=%0d rise=0x%02h fall=0x%02h pin_b=0x%02h expected cyc=%0d rise=0x%02h fall=0x%02h pin_b=0x%02h",
                   cyc, rise, fall, pin_b, e.cyc, e.rise, e.fall, e.pin_b);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    pins_in     = '0;
    irq_mask    = '0;
    pending_clr = '0;

    // Reset state
    tick(3);
    check("reset_pin_b", pin_b, 8'h00);
    check("reset_rise", rise, 8'h00);
    check("reset_fall", fall, 8'h00);
    check("reset_pending", pending, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;
    tick(2);

    // Basic rise on bit 0: pin_b at edge 6, rise for one cycle, pending, irq
    irq_mask = 8'h01;
    pins_in  = 8'h01;
    expect_evt(D + 2, 8'h01, 8'h00, 8'h01);
    tick(D + 1);
    check("lat_pin_b_edge5", pin_b, 8'h00);
    tick(1);
    check("lat_pin_b_edge6", pin_b, 8'h01);
    check("lat_rise_edge6", rise, 8'h01);
    tick(1);
    check("lat_rise_edge7", rise, 8'h00);
    check("lat_pending", pending, 8'h01);
    check("lat_irq", {7'b0, irq}, 8'h01);

    // Release bit 0: fall pulse, pending untouched
    pins_in = 8'h00;
    expect_evt(D + 2, 8'h00, 8'h01, 8'h00);
    tick(D + 3);
    check("fall_pin_b", pin_b, 8'h00);
    check("fall_pending_kept", pending, 8'h01);

    // Three-sample glitch on bit 3 must be ignored
    pins_in = 8'h08;
    tick(3);
    pins_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_pin_b", pin_b, 8'h00);
      check("glitch_pending", pending, 8'h01);
    end

    // Bounce 1,0,1... on bit 0; clear strobe coincides with the new rise
    pins_in = 8'h01;
    tick(1);
    pins_in = 8'h00;
    tick(1);
    pins_in = 8'h01;
    expect_evt(D + 2, 8'h01, 8'h00, 8'h01);
    tick(D + 1);
    check("bounce_pin_b_edge5", pin_b, 8'h00);
    tick(1);
    check("bounce_pin_b_edge6", pin_b, 8'h01);
    pending_clr = 8'h01;
    tick(1);
    check("clr_vs_rise_pending", pending, 8'h01);
    tick(1);
    pending_clr = 8'h00;
    check("clr_pending", pending, 8'h00);
    check("clr_irq", {7'b0, irq}, 8'h00);
    pins_in = 8'h00;
    expect_evt(D + 2, 8'h00, 8'h01, 8'h00);
    tick(D + 4);

    // Reset mid-debounce with all pins high, then fresh transitions
    pins_in = 8'hFF;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("rst_mid_pin_b", pin_b, 8'h00);
    check("rst_mid_rise", rise, 8'h00);
    check("rst_mid_pending", pending, 8'h00);
    tick(1);
    check("rst_mid2_pin_b", pin_b, 8'h00);
    reset = 1'b0;
    expect_evt(D + 2, 8'hFF, 8'h00, 8'hFF);
    tick(D + 1);
    check("post_rst_edge5", pin_b, 8'h00);
    tick(1);
    check("post_rst_edge6", pin_b, 8'hFF);
    check("post_rst_rise", rise, 8'hFF);
    tick(1);
    check("post_rst_rise_gone", rise, 8'h00);
    check("post_rst_pending", pending, 8'hFF);

    // Mask change acts on irq within the same cycle
    pending_clr = 8'h7F;
    tick(1);
    pending_clr = 8'h00;
    check("mask_pending", pending, 8'h80);
    irq_mask = 8'h00;
    #1;
    check("mask_irq_off", {7'b0, irq}, 8'h00);
    irq_mask = 8'h80;
    #1;
    check("mask_irq_on", {7'b0, irq}, 8'h01);
    check("mask_pending_kept", pending, 8'h80);

    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected events never seen", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
